// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants for the RV32M multiply/divide unit: op encodings,
// FSM state encoding and the default datapath width.
package ex_muldiv_unit_pkg;
  localparam int MD_XLEN = 32;

  localparam logic [2:0] MUL_F3    = 3'd0;
  localparam logic [2:0] MULH_F3   = 3'd1;
  localparam logic [2:0] MULHSU_F3 = 3'd2;
  localparam logic [2:0] MULHU_F3  = 3'd3;
  localparam logic [2:0] DIV_F3    = 3'd4;
  localparam logic [2:0] DIVU_F3   = 3'd5;
  localparam logic [2:0] REM_F3    = 3'd6;
  localparam logic [2:0] REMU_F3   = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DIV  = 2'd2;
  localparam state_t S_DONE = 2'd3;
endpackage

// File: rtl/ex_muldiv_unit_div_iter_core.sv
// Unsigned restoring divider, one quotient bit per cycle. quo_o/rem_o are the
// values produced by the current step, so the final step's result is usable on last_o.
module div_iter_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            last_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [XLEN:0]    shifted;
  logic             ge;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dvsr_q};
    rem_o   = ge ? XLEN'(shifted - {1'b0, dvsr_q}) : shifted[XLEN-1:0];
    quo_o   = {quo_q[XLEN-2:0], ge};
    last_o  = busy_q && (cnt_q == CNT_W'(XLEN-1));

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvsr_d = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_o;
      quo_d  = quo_o;
      cnt_d  = cnt_q + 1'b1;
      busy_d = !last_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M EX-stage multiply/divide unit: 2-cycle multiply, 33-cycle restoring
// divide, 1-cycle divide-by-zero/overflow. Stalls the front end while busy.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN      = MD_XLEN,
  parameter int DIV_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;

  logic            sgn_a, sgn_b, div_zero, div_ovf, div_start, div_last;
  logic [XLEN:0]   a_ext, b_ext;
  logic [XLEN-1:0] a_abs, b_abs, spec_res, mul_res, div_res, div_quo, div_rem;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sgn_a    = (funct3_i == MULH_F3) || (funct3_i == MULHSU_F3) ||
               (funct3_i == DIV_F3)  || (funct3_i == REM_F3);
    sgn_b    = (funct3_i == MULH_F3) || (funct3_i == DIV_F3) || (funct3_i == REM_F3);
    a_ext    = {sgn_a & rs1_data_i[XLEN-1], rs1_data_i};
    b_ext    = {sgn_b & rs2_data_i[XLEN-1], rs2_data_i};
    a_abs    = a_ext[XLEN] ? (~rs1_data_i + 1'b1) : rs1_data_i;
    b_abs    = b_ext[XLEN] ? (~rs2_data_i + 1'b1) : rs2_data_i;
    div_zero = (rs2_data_i == '0);
    // Only the signed ops can overflow: most-negative / -1
    div_ovf  = sgn_b && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_data_i);
    if (funct3_i[1]) spec_res = div_zero ? rs1_data_i : '0;
    else             spec_res = div_zero ? '1 : rs1_data_i;
  end

  // Sign-extending both operands to 2*XLEN makes the truncated product exact
  assign prod    = {{(XLEN-1){op_a_q[XLEN]}}, op_a_q} * {{(XLEN-1){op_b_q[XLEN]}}, op_b_q};
  assign mul_res = (funct3_q == MUL_F3) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign div_res = (funct3_q == REM_F3 || funct3_q == REMU_F3)
                 ? (neg_rem_q ? (~div_rem + 1'b1) : div_rem)
                 : (neg_quo_q ? (~div_quo + 1'b1) : div_quo);

  div_iter_core #(.XLEN(XLEN), .CNT_W(DIV_CNT_W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .flush_i    (flush_i),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .last_o     (div_last),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    div_start   = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid_i && !flush_i) begin
        funct3_d  = funct3_i;
        rd_d      = rd_i;
        op_a_d    = a_ext;
        op_b_d    = b_ext;
        neg_quo_d = a_ext[XLEN] ^ b_ext[XLEN];
        neg_rem_d = a_ext[XLEN];
        if (!funct3_i[2]) begin
          state_d = S_MUL;
        end else if (div_zero || div_ovf) begin
          result_d    = spec_res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          div_start = 1'b1;
          state_d   = S_DIV;
        end
      end
      S_MUL: if (flush_i) begin
        state_d = S_IDLE;
      end else begin
        result_d    = mul_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DIV: if (flush_i) begin
        state_d = S_IDLE;
      end else if (div_last) begin
        result_d    = div_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      funct3_q    <= '0;
      rd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign stall_o     = !flush_i && ((state_q == S_IDLE && in_valid_i) ||
                                    state_q == S_MUL || state_q == S_DIV);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign rd_o        = rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected {rd,result} pushed on issue,
// popped whenever out_valid_o is seen; latency and stall checked per op.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o, out_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .DIV_CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .funct3_i    (funct3_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .rd_i        (rd_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .out_valid_o (out_valid_o),
    .result_o    (result_o),
    .rd_o        (rd_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_o) begin
      if (sb_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("result", result_o, e[31:0]);
        chk("rd", {27'd0, rd_o}, {27'd0, e[36:32]});
      end
    end
  end

  // Issue one op, hold in_valid through DONE, then drop it
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int lat);
    int cyc, lowstall;
    @(negedge clk);
    in_valid_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_i = rd;
    sb_q.push_back({rd, exp});
    #1 chk({tag, "_stall_acc"}, {31'd0, stall_o}, 32'd1);
    cyc = 0; lowstall = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid_o) break;
      if (!stall_o) lowstall++;
    end
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_stall_busy"}, lowstall, 0);
    chk({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1 in_valid_i = 1'b0;
    @(negedge clk);
    chk({tag, "_single_pulse"}, {31'd0, out_valid_o}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid_i = 1'b0; funct3_i = '0; rs1_data_i = '0;
    rs2_data_i = '0; rd_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid",  {31'd0, out_valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd",     {27'd0, rd_o}, 32'd0);
    chk("rst_stall",  {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1;

    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 2);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 2);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 2);
    run_op("div",    3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'hFFFF_FFFA, 33);
    run_op("rem",    3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFE, 33);
    run_op("divu",   3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);
    run_op("remu",   3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33);
    run_op("divu0",  3'd5, 32'd5, 32'd0, 5'd9,  32'hFFFF_FFFF, 1);
    run_op("rem0",   3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);
    run_op("rd0",    3'd0, 32'd6, 32'd5, 5'd0, 32'd30, 2);

    // Flush mid-divide: never produces a result, stall drops immediately
    @(negedge clk);
    in_valid_i = 1'b1; funct3_i = 3'd5; rs1_data_i = 32'h1234_5678; rs2_data_i = 32'd3; rd_i = 5'd13;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1 chk("flush_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1 flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_idle", {31'd0, stall_o}, 32'd0);
    run_op("divu_after_flush", 3'd5, 32'd9, 32'd2, 5'd14, 32'd4, 33);

    // Asynchronous reset between edges in the middle of a divide
    @(negedge clk);
    in_valid_i = 1'b1; funct3_i = 3'd5; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_i = 5'd15;
    repeat (5) @(negedge clk);
    in_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  {31'd0, out_valid_o}, 32'd0);
    chk("arst_result", result_o, 32'd0);
    chk("arst_rd",     {27'd0, rd_o}, 32'd0);
    chk("arst_stall",  {31'd0, stall_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd16, 32'd12, 2);

    repeat (40) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
